// File: rtl/systolic_serial_multiplier.sv
// Bit-serial multiplier built as a linear systolic array of full-adder cells.
// The multiplier streams in LSB first; the product streams out of cell 0, LSB first.
module systolic_serial_multiplier #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_START,
    input  logic [WIDTH-1:0]     i_MULTIPLICAND,
    input  logic [WIDTH-1:0]     i_MULTIPLIER,
    output logic                 o_BUSY,
    output logic                 o_BIT_VALID,
    output logic                 o_PRODUCT_BIT,
    output logic                 o_DONE,
    output logic [2*WIDTH-1:0]   o_PRODUCT
);

    localparam int CELLS = (SIGNED != 0) ? 2*WIDTH : WIDTH;
    localparam int PW    = 2*WIDTH;
    localparam int CW    = $clog2(2*WIDTH+1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [CELLS-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CELLS-1:0]   r_sum;
    logic [CELLS-1:0]   r_carry;
    logic [PW-1:0]      r_shift;
    logic [PW-1:0]      r_product;
    logic               r_busy;
    logic               r_bit_valid;
    logic               r_done;

    logic               w_accept;
    logic               w_run_feed;
    logic               w_in_bit;
    logic               w_fill_in;
    logic               w_fill_run;
    logic [CELLS-1:0]   w_ext_a;
    logic [CELLS-1:0]   w_weight;
    logic [CELLS-1:0]   w_sum_next;
    logic [CELLS-1:0]   w_carry_next;

    assign w_accept   = i_START && (r_state != RUN);
    assign w_run_feed = (r_state == RUN) && (r_cnt != CW'(PW-1));

    // The acceptance edge already feeds B[0] into a cleared array, so bit k
    // of the product is on the output during the k-th RUN cycle.
    assign w_in_bit   = w_accept ? i_MULTIPLIER[0] : r_b[0];
    assign w_fill_in  = (SIGNED != 0) ? i_MULTIPLIER[WIDTH-1] : 1'b0;
    assign w_fill_run = (SIGNED != 0) ? r_b[WIDTH-1] : 1'b0;
    assign w_weight   = w_accept ? w_ext_a : r_a;

    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            logic       w_hi_sum;
            logic [1:0] w_total;

            if (gi < WIDTH) begin : g_lo
                assign w_ext_a[gi] = i_MULTIPLICAND[gi];
            end else begin : g_hi
                assign w_ext_a[gi] = i_MULTIPLICAND[WIDTH-1];
            end

            if (gi == CELLS-1) begin : g_top
                assign w_hi_sum = 1'b0;
            end else begin : g_mid
                assign w_hi_sum = r_sum[gi+1];
            end

            assign w_total = {1'b0, w_weight[gi] & w_in_bit}
                           + {1'b0, w_accept ? 1'b0 : r_carry[gi]}
                           + {1'b0, w_accept ? 1'b0 : w_hi_sum};
            assign w_sum_next[gi]   = w_total[0];
            assign w_carry_next[gi] = w_total[1];
        end
    endgenerate

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= '0;
            r_shift <= '0;
        end else if (w_accept) begin
            r_a     <= w_ext_a;
            r_b     <= {w_fill_in, i_MULTIPLIER[WIDTH-1:1]};
            r_sum   <= w_sum_next;
            r_carry <= w_carry_next;
            r_shift <= {w_sum_next[0], r_shift[PW-1:1]};
        end else if (w_run_feed) begin
            r_b     <= {w_fill_run, r_b[WIDTH-1:1]};
            r_sum   <= w_sum_next;
            r_carry <= w_carry_next;
            r_shift <= {w_sum_next[0], r_shift[PW-1:1]};
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_bit_valid <= 1'b0;
            r_done      <= 1'b0;
            r_product   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (i_START) begin
                        r_state     <= RUN;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_bit_valid <= 1'b1;
                    end else begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_bit_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (r_cnt == CW'(PW-1)) begin
                        r_state     <= DONE;
                        r_product   <= r_shift;
                        r_busy      <= 1'b0;
                        r_bit_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_bit_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_BUSY        = r_busy;
    assign o_BIT_VALID   = r_bit_valid;
    assign o_PRODUCT_BIT = r_sum[0];
    assign o_DONE        = r_done;
    assign o_PRODUCT     = r_product;

endmodule

// File: tb/tb_systolic_serial_multiplier.sv
// Directed bench for the serial multiplier: one unsigned and one signed
// instance share the same stimulus and are checked side by side.
module tb_systolic_serial_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  op_a;
    logic [7:0]  op_b;

    logic        u_busy, u_valid, u_bit, u_done;
    logic [15:0] u_prod;
    logic        s_busy, s_valid, s_bit, s_done;
    logic [15:0] s_prod;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_serial_multiplier #(.WIDTH(8), .SIGNED(0)) dut_u (
        .i_CLK(clk), .i_RST(rst), .i_START(start),
        .i_MULTIPLICAND(op_a), .i_MULTIPLIER(op_b),
        .o_BUSY(u_busy), .o_BIT_VALID(u_valid), .o_PRODUCT_BIT(u_bit),
        .o_DONE(u_done), .o_PRODUCT(u_prod)
    );

    systolic_serial_multiplier #(.WIDTH(8), .SIGNED(1)) dut_s (
        .i_CLK(clk), .i_RST(rst), .i_START(start),
        .i_MULTIPLICAND(op_a), .i_MULTIPLIER(op_b),
        .o_BUSY(s_busy), .o_BIT_VALID(s_valid), .o_PRODUCT_BIT(s_bit),
        .o_DONE(s_done), .o_PRODUCT(s_prod)
    );

    // Starts one operation and samples 17 cycles (16 RUN cycles plus DONE).
    // Cycle 0 is the cycle right after the acceptance edge. Operands are
    // scrambled after acceptance; poke_cycle pulses a second start mid-run.
    task automatic capture_op(input logic [7:0] a, input logic [7:0] b,
                              input int poke_cycle, input bit hold,
                              output logic [15:0] ser_u, output logic [15:0] ser_s,
                              output logic [15:0] prod_u, output logic [15:0] prod_s,
                              output logic [15:0] mid_u, output logic [15:0] mid_s,
                              output int done_u, output int done_s,
                              output int vcnt_u, output int vcnt_s);
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = hold; op_a = ~a; op_b = ~b;
        ser_u = '0; ser_s = '0; mid_u = '0; mid_s = '0;
        done_u = -1; done_s = -1; vcnt_u = 0; vcnt_s = 0;
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            if (u_valid) begin vcnt_u++; if (c < 16) ser_u[c] = u_bit; end
            if (s_valid) begin vcnt_s++; if (c < 16) ser_s[c] = s_bit; end
            if (u_done && done_u < 0) done_u = c;
            if (s_done && done_s < 0) done_s = c;
            if (c == 8) begin mid_u = u_prod; mid_s = s_prod; end
            if (c == poke_cycle) begin start = 1'b1; op_a = 8'hFF; op_b = 8'hFF; end
            else if (c == poke_cycle + 1) start = hold;
        end
        prod_u = u_prod; prod_s = s_prod;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; op_a = 8'h12; op_b = 8'h34;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (u_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_u: got %b want 0", u_busy); end
        checks++; if (u_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_u: got %b want 0", u_valid); end
        checks++; if (u_bit !== 1'b0) begin errors++; $display("FAIL reset_bit_u: got %b want 0", u_bit); end
        checks++; if (u_done !== 1'b0) begin errors++; $display("FAIL reset_done_u: got %b want 0", u_done); end
        checks++; if (u_prod !== 16'h0000) begin errors++; $display("FAIL reset_prod_u: got %h want 0000", u_prod); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_s: got %b want 0", s_busy); end
        checks++; if (s_prod !== 16'h0000) begin errors++; $display("FAIL reset_prod_s: got %h want 0000", s_prod); end
        $display("reset: busy=%b/%b prod=%h/%h", u_busy, s_busy, u_prod, s_prod);
    endtask

    // Directed vectors: A, B, expected unsigned product, expected signed product.
    task automatic test_vectors;
        logic [7:0]  va [6] = '{8'hFF, 8'h80, 8'hFF, 8'h7F, 8'h00, 8'h01};
        logic [7:0]  vb [6] = '{8'hFF, 8'h80, 8'h01, 8'h81, 8'hA5, 8'hA5};
        logic [15:0] eu [6] = '{16'hFE01, 16'h4000, 16'h00FF, 16'h3FFF, 16'h0000, 16'h00A5};
        logic [15:0] es [6] = '{16'h0001, 16'h4000, 16'hFFFF, 16'hC0FF, 16'h0000, 16'hFFA5};
        logic [15:0] ser_u, ser_s, prod_u, prod_s, mid_u, mid_s, prev_u;
        int done_u, done_s, vcnt_u, vcnt_s;
        prev_u = u_prod;
        for (int i = 0; i < 6; i++) begin
            capture_op(va[i], vb[i], -1, 1'b0, ser_u, ser_s, prod_u, prod_s,
                       mid_u, mid_s, done_u, done_s, vcnt_u, vcnt_s);
            $display("vec %0d: a=%h b=%h u=%h/%h s=%h/%h done=%0d/%0d", i, va[i], vb[i],
                     ser_u, prod_u, ser_s, prod_s, done_u, done_s);
            checks++; if (ser_u !== eu[i]) begin errors++; $display("FAIL vec%0d_serial_u: got %h want %h", i, ser_u, eu[i]); end
            checks++; if (prod_u !== eu[i]) begin errors++; $display("FAIL vec%0d_prod_u: got %h want %h", i, prod_u, eu[i]); end
            checks++; if (ser_s !== es[i]) begin errors++; $display("FAIL vec%0d_serial_s: got %h want %h", i, ser_s, es[i]); end
            checks++; if (prod_s !== es[i]) begin errors++; $display("FAIL vec%0d_prod_s: got %h want %h", i, prod_s, es[i]); end
            checks++; if (done_u !== 16 || done_s !== 16) begin errors++; $display("FAIL vec%0d_done_cycle: got %0d/%0d want 16", i, done_u, done_s); end
            checks++; if (vcnt_u !== 16 || vcnt_s !== 16) begin errors++; $display("FAIL vec%0d_valid_count: got %0d/%0d want 16", i, vcnt_u, vcnt_s); end
            checks++; if (mid_u !== prev_u) begin errors++; $display("FAIL vec%0d_prod_held: got %h want %h", i, mid_u, prev_u); end
            prev_u = eu[i];
        end
    endtask

    task automatic test_start_ignored;
        logic [15:0] ser_u, ser_s, prod_u, prod_s, mid_u, mid_s;
        int done_u, done_s, vcnt_u, vcnt_s;
        @(negedge clk);
        capture_op(8'h5A, 8'h3C, 5, 1'b0, ser_u, ser_s, prod_u, prod_s,
                   mid_u, mid_s, done_u, done_s, vcnt_u, vcnt_s);
        $display("start_ignored: u=%h s=%h done=%0d", prod_u, prod_s, done_u);
        checks++; if (prod_u !== 16'h1518) begin errors++; $display("FAIL ignore_prod_u: got %h want 1518", prod_u); end
        checks++; if (prod_s !== 16'h1518) begin errors++; $display("FAIL ignore_prod_s: got %h want 1518", prod_s); end
        checks++; if (done_u !== 16) begin errors++; $display("FAIL ignore_done_cycle: got %0d want 16", done_u); end
    endtask

    task automatic test_reset_midrun;
        logic [15:0] ser_u, ser_s, prod_u, prod_s, mid_u, mid_s;
        int done_u, done_s, vcnt_u, vcnt_s, done_seen;
        @(negedge clk);
        op_a = 8'hC3; op_b = 8'h99; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c <= 9; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({u_busy, u_valid, u_bit, u_done} !== 4'b0000) begin errors++; $display("FAIL midrst_flags_u: got %b want 0000", {u_busy, u_valid, u_bit, u_done}); end
        checks++; if ({s_busy, s_valid, s_bit, s_done} !== 4'b0000) begin errors++; $display("FAIL midrst_flags_s: got %b want 0000", {s_busy, s_valid, s_bit, s_done}); end
        checks++; if (u_prod !== 16'h0000 || s_prod !== 16'h0000) begin errors++; $display("FAIL midrst_prod: got %h/%h want 0000", u_prod, s_prod); end
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (u_done || s_done || u_busy) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d want 0", done_seen); end
        capture_op(8'h0D, 8'hB3, -1, 1'b0, ser_u, ser_s, prod_u, prod_s,
                   mid_u, mid_s, done_u, done_s, vcnt_u, vcnt_s);
        $display("reset_midrun: u=%h s=%h", prod_u, prod_s);
        checks++; if (prod_u !== 16'h0917) begin errors++; $display("FAIL midrst_after_u: got %h want 0917", prod_u); end
        checks++; if (prod_s !== 16'hFC17) begin errors++; $display("FAIL midrst_after_s: got %h want FC17", prod_s); end
    endtask

    // Start held high: each operation is accepted from DONE, so DONE recurs every 17 cycles.
    task automatic test_back_to_back;
        logic [15:0] ser_u, ser_s, prod_u, prod_s, mid_u, mid_s, eu, es;
        int done_u, done_s, vcnt_u, vcnt_s;
        logic [7:0] a, b;
        time t_done, t_prev;
        @(negedge clk);
        t_prev = 0;
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom_range(255));
            b = 8'($urandom_range(255));
            eu = {8'h00, a} * {8'h00, b};
            es = {{8{a[7]}}, a} * {{8{b[7]}}, b};
            capture_op(a, b, -1, 1'b1, ser_u, ser_s, prod_u, prod_s,
                       mid_u, mid_s, done_u, done_s, vcnt_u, vcnt_s);
            t_done = $time;
            $display("b2b %0d: a=%h b=%h u=%h s=%h done=%0d t=%0t", i, a, b, prod_u, prod_s, done_u, t_done);
            checks++; if (prod_u !== eu) begin errors++; $display("FAIL b2b%0d_prod_u: got %h want %h", i, prod_u, eu); end
            checks++; if (prod_s !== es) begin errors++; $display("FAIL b2b%0d_prod_s: got %h want %h", i, prod_s, es); end
            checks++; if (ser_s !== es) begin errors++; $display("FAIL b2b%0d_serial_s: got %h want %h", i, ser_s, es); end
            checks++; if (done_u !== 16) begin errors++; $display("FAIL b2b%0d_done_cycle: got %0d want 16", i, done_u); end
            if (i > 0) begin
                checks++; if (t_done - t_prev !== 170) begin errors++; $display("FAIL b2b%0d_period: got %0t want 170", i, t_done - t_prev); end
            end
            t_prev = t_done;
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        test_reset;
        test_vectors;
        test_start_ignored;
        test_reset_midrun;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
